// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl -- control FSM for an unsigned restoring divider.
//
// Drives the A (partial remainder), Q (dividend/quotient) and M (divisor)
// registers and the add/sub unit of an external datapath. One start/done
// handshake per division. Each quotient bit takes three cycles:
// SHIFT, SUB and TEST. TEST restores A when the trial subtraction went
// negative.
//
// Optional feature, controlled by the macro DIV_ZERO_CHK_EN:
//   defined   -> a zero divisor seen in INIT skips the iterations.
//                The FSM goes straight to DONE with o_err set.
//   undefined -> i_m_zero is ignored and o_err is tied low. A zero
//                divisor runs the full schedule.
module div_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_a_msb,
  input  logic i_m_zero,
  output logic o_clr_a,
  output logic o_en_q,
  output logic o_en_m,
  output logic o_shift,
  output logic o_en_a,
  output logic o_alu_sub,
  output logic o_q0_wr,
  output logic o_q0_val,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_SUB   = 3'd3;
  localparam logic [2:0] S_TEST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             busy_st;
  logic             abort_now;
  logic             last_iter;
  logic             zero_div;

  // INIT through TEST are the states an abort can cancel. DONE is
  // excluded so that a pending done pulse always completes.
  assign busy_st   = (state == S_INIT) || (state == S_SHIFT) ||
                     (state == S_SUB)  || (state == S_TEST);
  assign abort_now = i_abort && busy_st;
  assign last_iter = (count == CNT_ONE);

`ifdef DIV_ZERO_CHK_EN
  assign zero_div = i_m_zero;
`else
  logic unused_m_zero;
  assign zero_div      = 1'b0;
  assign unused_m_zero = i_m_zero;
`endif

  // Next-state and iteration-counter logic.
  // The counter is loaded only in INIT and drains to zero by the last
  // TEST. Every path back to IDLE leaves it at zero, so it never wraps.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_INIT;
      end
      S_INIT: begin
        if (zero_div) begin
          state_nxt = S_DONE;
          count_nxt = '0;
        end else begin
          state_nxt = S_SHIFT;
          count_nxt = CNT_LOAD;
        end
      end
      S_SHIFT: begin
        state_nxt = S_SUB;
      end
      S_SUB: begin
        state_nxt = S_TEST;
      end
      S_TEST: begin
        count_nxt = count - CNT_ONE;
        state_nxt = last_iter ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
    if (abort_now) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
    end
  end

  // State and counter registers with asynchronous reset to IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

`ifdef DIV_ZERO_CHK_EN
  logic err_q;

  // The error flag is re-evaluated on every INIT and is then held
  // through DONE, so it stays valid alongside the done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if ((state == S_INIT) && !abort_now) begin
      err_q <= zero_div;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_busy = (state != S_IDLE);

  // Strobe decode from the state register.
  // TEST also depends on i_a_msb: the sign of the trial subtraction
  // chooses the quotient bit and whether A is restored with A+M.
  // An abort cancels all strobes in the cycle in which it is seen.
  always_comb begin
    o_clr_a   = 1'b0;
    o_en_q    = 1'b0;
    o_en_m    = 1'b0;
    o_shift   = 1'b0;
    o_en_a    = 1'b0;
    o_alu_sub = 1'b0;
    o_q0_wr   = 1'b0;
    o_q0_val  = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_INIT: begin
        o_clr_a = 1'b1;
        o_en_q  = 1'b1;
        o_en_m  = 1'b1;
      end
      S_SHIFT: begin
        o_shift = 1'b1;
      end
      S_SUB: begin
        o_en_a    = 1'b1;
        o_alu_sub = 1'b1;
      end
      S_TEST: begin
        o_q0_wr  = 1'b1;
        o_q0_val = ~i_a_msb;
        if (i_a_msb) begin
          o_en_a    = 1'b1;
          o_alu_sub = 1'b0;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
    if (abort_now) begin
      o_clr_a   = 1'b0;
      o_en_q    = 1'b0;
      o_en_m    = 1'b0;
      o_shift   = 1'b0;
      o_en_a    = 1'b0;
      o_alu_sub = 1'b0;
      o_q0_wr   = 1'b0;
      o_q0_val  = 1'b0;
    end
  end

endmodule
